// File: rtl/dec_pkg.sv
// Shared types and constants for the decrypted-block writer.
package dec_pkg;

  localparam int unsigned AES_BLK_BYTES     = 16;
  localparam int unsigned AES_BLK_W         = 128;
  localparam int unsigned IMG_BYTES_DEFAULT = 19200;

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef DEC_WRITER_CLEAR_EN
    ST_CLEAR,
`endif
    ST_ACCEPT,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/blk_shift_reg.sv
// 128-bit block register: parallel load, shift left by one byte, MSB byte out,
// byte index flags the last byte of the block.
module blk_shift_reg
  import dec_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic [AES_BLK_W-1:0] din,
  output logic [7:0]           byte_out,
  output logic                 last
);

  logic [AES_BLK_W-1:0] data;
  logic [3:0]           idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      idx  <= '0;
    end else if (load) begin
      data <= din;
      idx  <= '0;
    end else if (shift) begin
      data <= {data[AES_BLK_W-9:0], 8'h00};
      idx  <= idx + 4'd1;
    end
  end

  assign byte_out = data[AES_BLK_W-1 -: 8];
  assign last     = (idx == 4'(AES_BLK_BYTES - 1));

endmodule

// File: rtl/dec_block_writer.sv
// Serializes decrypted 128-bit blocks into byte writes on decryption memory port A.
// Optional DEC_WRITER_CLEAR_EN: zero-fill the whole image before accepting blocks.
module dec_block_writer
  import dec_pkg::*;
#(
  parameter int unsigned IMG_BYTES = IMG_BYTES_DEFAULT,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 blk_valid,
  input  logic [AES_BLK_W-1:0] blk_data,
  output logic                 blk_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_din,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-5:0]    blk_count
);

  localparam int unsigned       CNT_W     = ADDR_W - 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

  state_t            state, state_nxt;
  logic              start_ok, accept, byte_last, at_last_addr;
  logic              ready_nxt, we_nxt, busy_nxt, done_nxt;
  logic [ADDR_W-1:0] addr;

  assign start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign accept       = blk_valid && blk_ready;
  assign at_last_addr = (addr == LAST_ADDR);
  assign mem_addr     = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
`ifdef DEC_WRITER_CLEAR_EN
          state_nxt = ST_CLEAR;
`else
          state_nxt = ST_ACCEPT;
`endif
        end
      end
`ifdef DEC_WRITER_CLEAR_EN
      ST_CLEAR:  if (at_last_addr) state_nxt = ST_ACCEPT;
`endif
      ST_ACCEPT: if (accept) state_nxt = ST_WRITE;
      ST_WRITE:  if (byte_last) state_nxt = at_last_addr ? ST_DONE : ST_ACCEPT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they align with state.
  always_comb begin
    ready_nxt = (state_nxt == ST_ACCEPT);
    we_nxt    = (state_nxt == ST_WRITE);
    busy_nxt  = (state_nxt == ST_ACCEPT) || (state_nxt == ST_WRITE);
    done_nxt  = (state_nxt == ST_DONE);
`ifdef DEC_WRITER_CLEAR_EN
    we_nxt    = we_nxt   || (state_nxt == ST_CLEAR);
    busy_nxt  = busy_nxt || (state_nxt == ST_CLEAR);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_ready <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      blk_ready <= ready_nxt;
      mem_we    <= we_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // The address holds at IMG_BYTES-1 after the final byte; only a new start rewinds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      blk_count <= '0;
    end else if (start_ok) begin
      addr      <= '0;
      blk_count <= '0;
    end else begin
      case (state)
`ifdef DEC_WRITER_CLEAR_EN
        ST_CLEAR: addr <= at_last_addr ? '0 : addr + ADDR_W'(1);
`endif
        ST_WRITE: begin
          if (!at_last_addr) addr <= addr + ADDR_W'(1);
          if (byte_last)     blk_count <= blk_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Loading zeros on start keeps mem_din at 0x00 during the clear pass.
  blk_shift_reg u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_ok || accept),
    .shift    (state == ST_WRITE),
    .din      (accept ? blk_data : '0),
    .byte_out (mem_din),
    .last     (byte_last)
  );

endmodule

// File: tb/tb_dec_block_writer.sv
// Directed self-checking bench for dec_block_writer (IMG_BYTES = 48, three blocks).
module tb_dec_block_writer;

  localparam int unsigned IMG = 48;
  localparam int unsigned AW  = 15;
  localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] BLK_B = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          blk_valid = 1'b0;
  logic [127:0]  blk_data = '0;
  logic          blk_ready, mem_we, busy, done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [AW-5:0] blk_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned t0 = 0;

  dec_block_writer #(.IMG_BYTES(IMG), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_ready (blk_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .busy      (busy),
    .done      (done),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, blk_ready, 0);
    check({tag, "_we"},    mem_we,    0);
    check({tag, "_addr"},  mem_addr,  0);
    check({tag, "_din"},   mem_din,   0);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_done"},  done,      0);
    check({tag, "_cnt"},   blk_count, 0);
  endtask

  // Waits (bounded) for a write, checks it, then moves to the next negedge.
  task automatic expect_write(input string tag, input int unsigned a, input logic [7:0] d);
    int unsigned n = 0;
    while (mem_we !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_we"},   mem_we,   1);
    check({tag, "_addr"}, mem_addr, a);
    check({tag, "_din"},  mem_din,  d);
    @(negedge clk);
  endtask

  // Pulses start; returns at the negedge where the writer should be accepting.
  task automatic start_frame(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done"}, done,      0);
    check({tag, "_cnt"},  blk_count, 0);
    check({tag, "_addr"}, mem_addr,  0);
    check({tag, "_busy"}, busy,      1);
`ifdef DEC_WRITER_CLEAR_EN
    for (int i = 0; i < IMG; i++) begin
      check($sformatf("%s_clr%0d_we", tag, i),    mem_we,    1);
      check($sformatf("%s_clr%0d_addr", tag, i),  mem_addr,  i);
      check($sformatf("%s_clr%0d_din", tag, i),   mem_din,   0);
      check($sformatf("%s_clr%0d_ready", tag, i), blk_ready, 0);
      @(negedge clk);
    end
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Block 1: data changes after the handshake must not affect the bytes written.
    blk_data  = BLK_A;
    blk_valid = 1'b1;
    start_frame("f1");
    check("f1_ready", blk_ready, 1);
    check("f1_we0",   mem_we,    0);
    @(negedge clk);
    blk_valid = 1'b0;
    blk_data  = BLK_B;
    for (int i = 0; i < 16; i++)
      expect_write($sformatf("b1_%0d", i), i, 8'(i * 17));
    check("b1_cnt",   blk_count, 1);
    check("b1_ready", blk_ready, 1);

    // Five-cycle gap with no valid block.
    repeat (5) begin
      check("gap_we",    mem_we,    0);
      check("gap_ready", blk_ready, 1);
      @(negedge clk);
    end
    blk_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      expect_write($sformatf("b2_%0d", i), 16 + i, 8'((i + 1) * 15));
      if (i == 0) blk_data = BLK_A;
    end
    check("b2_cnt", blk_count, 2);

    // Block 3: reset lands while byte 7 is on the bus.
    for (int i = 0; i < 7; i++)
      expect_write($sformatf("b3_%0d", i), 32 + i, 8'(i * 17));
    check("b3_byte7_we",   mem_we,   1);
    check("b3_byte7_addr", mem_addr, 39);
    check("b3_byte7_din",  mem_din,  8'h77);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    blk_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");

    // Full frame; start pulsed mid-block must be ignored.
    blk_data  = BLK_A;
    blk_valid = 1'b1;
    start_frame("f2");
    t0 = cyc;
    check("f2_ready", blk_ready, 1);
    for (int i = 0; i < IMG; i++) begin
      start = (i == 3);
      expect_write($sformatf("f2_%0d", i), i, 8'((i % 16) * 17));
    end
    start = 1'b0;
    begin
      int unsigned n = 0;
      while (done !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("done_latency", cyc - t0, 51);
    check("done_flag",    done,      1);
    check("done_busy",    busy,      0);
    check("done_addr",    mem_addr,  47);
    check("done_cnt",     blk_count, 3);
    check("done_ready",   blk_ready, 0);
    check("done_we",      mem_we,    0);

    // Restart from DONE.
    start_frame("f3");
    check("f3_ready", blk_ready, 1);
    expect_write("f3_0", 0, 8'h00);
    expect_write("f3_1", 1, 8'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
